// File: rtl/pool_stride_filter_pkg.sv
// Shared types and elaboration helpers for the pooled-output stride filter.
package pool_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pool_state_e;

  localparam int unsigned DEF_IMG_DIM    = 13;
  localparam int unsigned DEF_KERNEL_DIM = 3;
  localparam int unsigned DEF_STRIDE     = 2;

  function automatic int unsigned out_dim(int unsigned img, int unsigned k, int unsigned s);
    return (img - k) / s + 1;
  endfunction

  function automatic int unsigned pos_w(int unsigned img);
    return (img < 2) ? 1 : $clog2(img);
  endfunction

  function automatic int unsigned phase_w(int unsigned s);
    return (s < 2) ? 1 : $clog2(s);
  endfunction

  localparam int unsigned POS_W   = pos_w(DEF_IMG_DIM);
  localparam int unsigned PHASE_W = phase_w(DEF_STRIDE);

endpackage

// File: rtl/pool_stride_filter_if.sv
// Beat/data bundle between the max-pool stage, this filter and the next layer buffer.
interface pool_stride_filter_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CHANNELS  = 256
);
  logic [CHANNELS-1:0]           i_we;
  logic [DATA_SIZE*CHANNELS-1:0] i_data;
  logic                          i_sync;
  logic                          i_next_ready;
  logic                          o_ready;
  logic [CHANNELS-1:0]           o_next_we;
  logic [DATA_SIZE*CHANNELS-1:0] o_next_data;
  logic                          o_next_start;
  logic                          o_busy;
  logic                          o_err;

  modport master (
    output i_we, i_data, i_sync, i_next_ready,
    input  o_ready, o_next_we, o_next_data, o_next_start, o_busy, o_err
  );

  modport slave (
    input  i_we, i_data, i_sync, i_next_ready,
    output o_ready, o_next_we, o_next_data, o_next_start, o_busy, o_err
  );
endinterface

// File: rtl/pool_stride_filter_axis_counter.sv
// One raster axis: position counter plus stride phase that starts at the first full window.
module pool_axis_counter
  import pool_pkg::*;
#(
  parameter  int unsigned IMG_DIM    = 13,
  parameter  int unsigned KERNEL_DIM = 3,
  parameter  int unsigned STRIDE     = 2,
  localparam int unsigned PW         = pos_w(IMG_DIM),
  localparam int unsigned PHW        = phase_w(STRIDE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] pos,
  output logic          on_grid,
  output logic          wrap
);

  logic [PW-1:0]  pos_q, pos_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic           at_last;
  logic           in_window;

  always_comb begin
    at_last   = (pos_q == PW'(IMG_DIM - 1));
    in_window = (pos_q >= PW'(KERNEL_DIM - 1));
    on_grid   = in_window && (phase_q == '0);
    wrap      = inc && at_last && !clr;
    pos_d     = pos_q;
    phase_d   = phase_q;
    if (clr) begin
      pos_d   = '0;
      phase_d = '0;
    end else if (inc) begin
      if (at_last) begin
        pos_d   = '0;
        phase_d = '0;
      end else begin
        pos_d = pos_q + 1'b1;
        // phase only moves once the window fits, so it reads (pos-K+1) mod STRIDE
        if (in_window) begin
          phase_d = (phase_q == PHW'(STRIDE - 1)) ? '0 : phase_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      phase_q <= '0;
    end else begin
      pos_q   <= pos_d;
      phase_q <= phase_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/pool_stride_filter.sv
// Keeps only on-grid, fully-inside pool windows, registers them for the next layer
// and pulses start once the frame's last output has gone out.
module pool_stride_filter
  import pool_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = 8,
  parameter int unsigned CHANNELS   = 256,
  parameter int unsigned IMG_DIM    = 13,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned STRIDE     = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  pool_stride_filter_if.slave bus
);

  localparam int unsigned PW = pos_w(IMG_DIM);
  localparam int unsigned DW = DATA_SIZE * CHANNELS;

  pool_state_e         state_q, state_d;
  logic                v1_q, v1_d;
  logic                l1_q, l1_d;
  logic                l2_q, l2_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] we_q, we_d;
  logic [DW-1:0]       data_q, data_d;

  logic          beat, inc, lockstep_bad;
  logic          col_grid, col_wrap, row_grid, row_wrap;
  logic [PW-1:0] col_pos, row_pos;
  logic          unused_pos;

  assign beat         = |bus.i_we;
  assign inc          = beat && !bus.i_sync;
  assign lockstep_bad = beat && (bus.i_we != '1);

  pool_axis_counter #(
    .IMG_DIM   (IMG_DIM),
    .KERNEL_DIM(KERNEL_DIM),
    .STRIDE    (STRIDE)
  ) u_col (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (inc),
    .clr    (bus.i_sync),
    .pos    (col_pos),
    .on_grid(col_grid),
    .wrap   (col_wrap)
  );

  pool_axis_counter #(
    .IMG_DIM   (IMG_DIM),
    .KERNEL_DIM(KERNEL_DIM),
    .STRIDE    (STRIDE)
  ) u_row (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (col_wrap),
    .clr    (bus.i_sync),
    .pos    (row_pos),
    .on_grid(row_grid),
    .wrap   (row_wrap)
  );

  assign unused_pos = ^{col_pos, row_pos};

  always_comb begin
    state_d = state_q;
    v1_d    = 1'b0;
    l1_d    = 1'b0;
    l2_d    = 1'b0;
    start_d = 1'b0;
    we_d    = '0;
    data_d  = data_q;
    err_d   = err_q | lockstep_bad | ((|we_q) && !bus.i_next_ready);
    if (bus.i_sync) begin
      state_d = IDLE;
    end else begin
      v1_d    = inc && col_grid && row_grid;
      // a row wrap only happens on the frame's final pixel
      l1_d    = row_wrap;
      l2_d    = l1_q;
      start_d = l2_q;
      we_d    = {CHANNELS{v1_q}};
      if (v1_q) data_d = bus.i_data;
      if (inc) state_d = row_wrap ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v1_q    <= 1'b0;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      v1_q    <= v1_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      start_q <= start_d;
      err_q   <= err_d;
      we_q    <= we_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_ready      = bus.i_next_ready;
  assign bus.o_next_we    = we_q;
  assign bus.o_next_data  = data_q;
  assign bus.o_next_start = start_q;
  assign bus.o_busy       = (state_q == RUN);
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_pool_stride_filter.sv
// Directed bench: 13x13/K3/S2 and 5x5/K3/S1 filters fed by a small pool-stage model.
module tb_pool_stride_filter;
  import pool_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned CH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_stride_filter_if #(.DATA_SIZE(DW), .CHANNELS(CH)) a_if ();
  pool_stride_filter_if #(.DATA_SIZE(DW), .CHANNELS(CH)) b_if ();

  pool_stride_filter #(
    .DATA_SIZE(DW), .CHANNELS(CH), .IMG_DIM(13), .KERNEL_DIM(3), .STRIDE(2)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

  pool_stride_filter #(
    .DATA_SIZE(DW), .CHANNELS(CH), .IMG_DIM(5), .KERNEL_DIM(3), .STRIDE(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  int a_wr_data[$], a_wr_cyc[$], a_st_cyc[$], a_beat_cyc[$];
  int b_wr_data[$], b_wr_cyc[$], b_st_cyc[$];
  int golden_a[$];
  int lane_bad = 0;
  int a_pix = 0, b_pix = 0;
  int a_p, b_p;
  logic a_v, b_v;

  // pool stage model: data for a beat shows up the following cycle
  always @(posedge clk) begin
    a_v = (a_if.i_we != '0);
    a_p = a_pix;
    b_v = (b_if.i_we != '0);
    b_p = b_pix;
    #1;
    if (a_v) a_if.i_data = {CH{a_p[7:0]}};
    if (b_v) b_if.i_data = {CH{b_p[7:0]}};
  end

  always @(negedge clk) begin
    if (a_if.o_next_we == '1) begin
      a_wr_data.push_back(int'(a_if.o_next_data[7:0]));
      a_wr_cyc.push_back(cyc);
      if (a_if.o_next_data !== {CH{a_if.o_next_data[7:0]}}) lane_bad++;
    end else if (a_if.o_next_we != '0) lane_bad++;
    if (a_if.o_next_start) a_st_cyc.push_back(cyc);
    if (b_if.o_next_we == '1) begin
      b_wr_data.push_back(int'(b_if.o_next_data[7:0]));
      b_wr_cyc.push_back(cyc);
    end else if (b_if.o_next_we != '0) lane_bad++;
    if (b_if.o_next_start) b_st_cyc.push_back(cyc);
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(int sel, logic [CH-1:0] we, int pix, logic sync);
    @(posedge clk);
    #1;
    a_if.i_we = '0; a_if.i_sync = 1'b0;
    b_if.i_we = '0; b_if.i_sync = 1'b0;
    if (sel == 0) begin
      a_if.i_we = we; a_if.i_sync = sync; a_pix = pix;
      if (we != '0 && !sync) a_beat_cyc.push_back(cyc);
    end else begin
      b_if.i_we = we; b_if.i_sync = sync; b_pix = pix;
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, '0, 0, 1'b0);
  endtask

  task automatic clear_q();
    a_wr_data.delete(); a_wr_cyc.delete(); a_st_cyc.delete(); a_beat_cyc.delete();
    b_wr_data.delete(); b_wr_cyc.delete(); b_st_cyc.delete();
  endtask

  task automatic frame_a(int gap_max);
    for (int i = 0; i < 169; i++) begin
      step(0, '1, i, 1'b0);
      if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
    end
  endtask

  task automatic check_frame_a(string tag);
    int bad, lat_bad, n;
    bad = 0; lat_bad = 0;
    n = (a_wr_data.size() < 36) ? a_wr_data.size() : 36;
    chk({tag, "_count"}, a_wr_data.size(), 36);
    for (int k = 0; k < n; k++) begin
      if (a_wr_data[k] != golden_a[k]) bad++;
      if (a_wr_cyc[k] - a_beat_cyc[golden_a[k]] != 2) lat_bad++;
    end
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_latency"}, lat_bad, 0);
    if (n > 1) begin
      chk({tag, "_first"}, a_wr_data[0], 28);
      chk({tag, "_second"}, a_wr_data[1], 30);
      chk({tag, "_last"}, a_wr_data[n-1], 168);
    end
    chk({tag, "_starts"}, a_st_cyc.size(), 1);
    if (a_st_cyc.size() > 0 && n > 0)
      chk({tag, "_start_at"}, a_st_cyc[0], a_wr_cyc[n-1] + 1);
    chk({tag, "_err"}, a_if.o_err, 0);
    chk({tag, "_busy"}, a_if.o_busy, 0);
    chk({tag, "_lanes"}, lane_bad, 0);
  endtask

  initial begin
    int exp_b[9];
    int bad, stale, sync_cyc;
    exp_b = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    for (int r = 0; r < 13; r++)
      for (int c = 0; c < 13; c++)
        if (r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0)
          golden_a.push_back(r * 13 + c);

    a_if.i_we = '0; a_if.i_data = '0; a_if.i_sync = 1'b0; a_if.i_next_ready = 1'b1;
    b_if.i_we = '0; b_if.i_data = '0; b_if.i_sync = 1'b0; b_if.i_next_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", a_if.o_next_we, 0);
    chk("rst_data", a_if.o_next_data, 0);
    chk("rst_start", a_if.o_next_start, 0);
    chk("rst_err", a_if.o_err, 0);
    chk("rst_busy", a_if.o_busy, 0);
    chk("rst_ready", a_if.o_ready, 1);
    rst_n = 1'b1;

    // 1: back-to-back frame
    clear_q();
    step(0, '1, 0, 1'b0);
    step(0, '1, 1, 1'b0);
    chk("c1_busy", a_if.o_busy, 1);
    for (int i = 2; i < 169; i++) step(0, '1, i, 1'b0);
    idle(5);
    check_frame_a("c1");

    // 2: random idle gaps
    clear_q();
    frame_a(3);
    idle(5);
    check_frame_a("c2");

    // 3: 5x5, stride 1, two frames back to back
    clear_q();
    for (int i = 0; i < 50; i++) step(1, '1, i % 25, 1'b0);
    repeat (5) step(1, '0, 0, 1'b0);
    chk("c3_count", b_wr_data.size(), 18);
    bad = 0;
    for (int k = 0; k < b_wr_data.size() && k < 18; k++)
      if (b_wr_data[k] != exp_b[k % 9]) bad++;
    chk("c3_seq", bad, 0);
    chk("c3_starts", b_st_cyc.size(), 2);
    if (b_st_cyc.size() == 2 && b_wr_data.size() == 18) begin
      chk("c3_start0_at", b_st_cyc[0], b_wr_cyc[8] + 1);
      chk("c3_start1_at", b_st_cyc[1], b_wr_cyc[17] + 1);
    end

    // 4: reset mid-frame
    clear_q();
    for (int i = 0; i <= 50; i++) step(0, '1, i, 1'b0);
    step(0, '0, 0, 1'b0);
    chk("c4_pre_busy", a_if.o_busy, 1);
    chk("c4_pre_data", a_if.o_next_data[7:0], 38);
    #2 rst_n = 1'b0;
    #1;
    chk("c4_rst_we", a_if.o_next_we, 0);
    chk("c4_rst_data", a_if.o_next_data, 0);
    chk("c4_rst_start", a_if.o_next_start, 0);
    chk("c4_rst_busy", a_if.o_busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_q();
    frame_a(0);
    idle(5);
    check_frame_a("c4");

    // 5: sync coincident with beat 40
    clear_q();
    for (int i = 0; i < 40; i++) step(0, '1, i, 1'b0);
    step(0, '1, 40, 1'b1);
    sync_cyc = cyc;
    idle(4);
    stale = 0;
    foreach (a_wr_cyc[k]) if (a_wr_cyc[k] > sync_cyc) stale++;
    chk("c5_stale", stale, 0);
    chk("c5_busy", a_if.o_busy, 0);
    clear_q();
    frame_a(0);
    idle(5);
    check_frame_a("c5");

    // 6a: lockstep violation, sticky through sync
    step(0, CH'(8'h01), 0, 1'b0);
    idle(1);
    chk("c6_lock_err", a_if.o_err, 1);
    step(0, '0, 0, 1'b1);
    idle(2);
    chk("c6_lock_held", a_if.o_err, 1);
    rst_n = 1'b0;
    #1;
    chk("c6_rst_err", a_if.o_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 6b: write while next layer not ready
    clear_q();
    a_if.i_next_ready = 1'b0;
    for (int i = 0; i < 28; i++) step(0, '1, i, 1'b0);
    idle(2);
    chk("c6_ready_out", a_if.o_ready, 0);
    chk("c6_err_before", a_if.o_err, 0);
    step(0, '1, 28, 1'b0);
    idle(3);
    chk("c6_err_after", a_if.o_err, 1);
    chk("c6_wr_count", a_wr_data.size(), 1);
    if (a_wr_data.size() > 0) chk("c6_wr_data", a_wr_data[0], 28);
    a_if.i_next_ready = 1'b1;
    #1;
    chk("c6_ready_on", a_if.o_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
